// File: rtl/uart_tx_arbiter_if.sv
// Client-side and transmitter-side signals of the shared UART transmit path.
// The master side drives requests and the done pulse; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   i_req;
  logic [8*N_REQ-1:0] i_data;
  logic [N_REQ-1:0]   i_last;
  logic [N_REQ-1:0]   o_ack;
  logic               o_write;
  logic [7:0]         o_wdata;
  logic               i_tx_done;

  modport master (
    output i_req, i_data, i_last, i_tx_done,
    input  o_ack, o_write, o_wdata
  );

  modport slave (
    input  i_req, i_data, i_last, i_tx_done,
    output o_ack, o_write, o_wdata
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter that shares one UART transmitter FIFO between
// N_REQ byte sources, using a credit counter to keep that FIFO from overflowing.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  uart_tx_arbiter_if.slave    bus,
  output logic [N_REQ-1:0]    o_grant,
  output logic [3:0]          o_credits,
  output logic                o_timeout,
  output logic                o_underflow
);

  localparam int RR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int CRED_W = 4;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic              timeout_q, timeout_d;
  logic              underflow_q, underflow_d;

  logic              hold_req, hold_last, found, write;
  logic [7:0]        hold_data;
  logic [RR_W-1:0]   cand;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    credits_d   = credits_q;
    idle_d      = idle_q;
    timeout_d   = timeout_q;
    underflow_d = underflow_q;
    hold_req    = 1'b0;
    hold_last   = 1'b0;
    hold_data   = '0;
    found       = 1'b0;
    cand        = '0;
    bus.o_ack   = '0;

    // While in GRANT, rr_q names the current holder.
    for (int r = 0; r < N_REQ; r++) begin
      if (RR_W'(r) == rr_q) begin
        hold_req  = bus.i_req[r];
        hold_last = bus.i_last[r];
        hold_data = bus.i_data[r*8 +: 8];
      end
    end

    case (state_q)
      IDLE: begin
        for (int i = 1; i <= N_REQ; i++) begin
          cand = RR_W'((int'(rr_q) + i) % N_REQ);
          if (!found && bus.i_req[cand]) begin
            found         = 1'b1;
            rr_d          = cand;
            grant_d       = '0;
            grant_d[cand] = 1'b1;
            idle_d        = '0;
            state_d       = GRANT;
          end
        end
      end
      GRANT: begin
        if (hold_req && (credits_q < CRED_W'(FIFO_DEPTH))) begin
          bus.o_ack[rr_q] = 1'b1;
          idle_d          = '0;
          if (hold_last) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (!hold_req) begin
          // A holder waiting on credits is not stalling, so only a dropped request counts.
          if (idle_q == CNT_W'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            grant_d   = '0;
            idle_d    = '0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    write       = |bus.o_ack;
    bus.o_write = write;
    bus.o_wdata = write ? hold_data : 8'h00;

    case ({write, bus.i_tx_done})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01: begin
        if (credits_q == '0) underflow_d = 1'b1;
        else                 credits_d   = credits_q - 1'b1;
      end
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so all updates land together.
    if (i_rst) begin
      state_q     <= IDLE;
      rr_q        <= RR_W'(N_REQ - 1);
      grant_q     <= '0;
      credits_q   <= '0;
      idle_q      <= '0;
      timeout_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      credits_q   <= credits_d;
      idle_q      <= idle_d;
      timeout_q   <= timeout_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_credits   = credits_q;
  assign o_timeout   = timeout_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues feed the DUT and a
// scoreboard of expected (source, byte) pairs is checked on every transmitter write.
module tb_uart_tx_arbiter;
  localparam int N_REQ      = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 255;

  logic             clk = 1'b0;
  logic             i_rst;
  logic [N_REQ-1:0] grant;
  logic [3:0]       credits;
  logic             timeout;
  logic             underflow;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(
    .N_REQ      (N_REQ),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .bus         (bus),
    .o_grant     (grant),
    .o_credits   (credits),
    .o_timeout   (timeout),
    .o_underflow (underflow)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } src_byte_t;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] d;
  } exp_t;

  src_byte_t        src_q [N_REQ][$];
  exp_t             exp_q [$];
  logic [N_REQ-1:0] mute;
  logic [N_REQ-1:0] samp_ack;
  logic             samp_write;
  int               checks;
  int               errors;
  int               ack_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < N_REQ; r++) begin
      if (src_q[r].size() > 0 && !mute[r]) begin
        bus.i_req[r]         = 1'b1;
        bus.i_data[r*8 +: 8] = src_q[r][0].d;
        bus.i_last[r]        = src_q[r][0].last;
      end else begin
        bus.i_req[r]         = 1'b0;
        bus.i_data[r*8 +: 8] = 8'h00;
        bus.i_last[r]        = 1'b0;
      end
    end
  endtask

  // One clock cycle: sample at the falling edge, then drive new inputs just after the rising edge.
  task automatic tick();
    exp_t e;
    #4;
    samp_ack   = bus.o_ack;
    samp_write = bus.o_write;
    check("ack_onehot0", {31'b0, $onehot0(samp_ack)}, 32'd1);
    for (int r = 0; r < N_REQ; r++)
      if (samp_ack[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
    if (samp_ack != '0) ack_cnt++;
    if (samp_write) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", {31'b0, samp_write}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_src", {28'b0, samp_ack}, 32'(1) << e.src);
        check("wr_data", {24'b0, bus.o_wdata}, {24'b0, e.d});
      end
    end else begin
      check("idle_wdata", {24'b0, bus.o_wdata}, 32'd0);
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  // Queue n bytes for requester r; the first n_exp of them are expected on the transmitter.
  task automatic push_pkt(input int r, input int n, input logic [7:0] base, input int n_exp);
    src_byte_t b;
    exp_t      e;
    for (int i = 0; i < n; i++) begin
      b.d    = base + 8'(i);
      b.last = (i == n - 1);
      src_q[r].push_back(b);
      if (i < n_exp) begin
        e.src = 2'(r);
        e.d   = base + 8'(i);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic reset_all();
    i_rst = 1'b1;
    for (int r = 0; r < N_REQ; r++) src_q[r].delete();
    exp_q.delete();
    mute          = '0;
    bus.i_tx_done = 1'b0;
    drive();
    tick();
    i_rst   = 1'b0;
    ack_cnt = 0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_bound", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    ack_cnt       = 0;
    mute          = '0;
    i_rst         = 1'b1;
    bus.i_tx_done = 1'b0;
    drive();
    @(posedge clk);
    #1;

    // Reset state
    reset_all();
    check("rst_grant", {28'b0, grant}, 32'd0);
    check("rst_credits", {28'b0, credits}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    check("rst_underflow", {31'b0, underflow}, 32'd0);
    tick();
    check("rst_ack", {28'b0, samp_ack}, 32'd0);
    check("rst_write", {31'b0, samp_write}, 32'd0);

    // Single 3-byte packet from requester 0
    reset_all();
    push_pkt(0, 3, 8'h41, 3);
    drive();
    tick();
    check("t1_no_ack_in_idle", {28'b0, samp_ack}, 32'd0);
    check("t1_grant", {28'b0, grant}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_ack", {28'b0, samp_ack}, 32'd1);
    end
    check("t1_release", {28'b0, grant}, 32'd0);
    check("t1_credits", {28'b0, credits}, 32'd3);
    check("t1_drained", exp_q.size(), 32'd0);

    // Round-robin fairness: requester 0, then 2, then 0 again, packets never interleaved
    reset_all();
    push_pkt(0, 2, 8'h10, 2);
    push_pkt(2, 2, 8'h20, 2);
    push_pkt(0, 2, 8'h30, 2);
    drive();
    wait_drain(40);
    check("t2_credits", {28'b0, credits}, 32'd6);

    // Credit stall at full FIFO, one more byte after a done pulse
    reset_all();
    push_pkt(1, 12, 8'h60, 12);
    drive();
    repeat (20) tick();
    check("t3_acks_at_full", ack_cnt, 32'd8);
    check("t3_credits_full", {28'b0, credits}, 32'd8);
    check("t3_stalled", {28'b0, samp_ack}, 32'd0);
    check("t3_still_granted", {28'b0, grant}, 32'd2);
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    check("t3_no_ack_on_done", {28'b0, samp_ack}, 32'd0);
    check("t3_credits_after_done", {28'b0, credits}, 32'd7);
    tick();
    check("t3_resume_ack", {28'b0, samp_ack}, 32'd2);
    check("t3_credits_refull", {28'b0, credits}, 32'd8);
    repeat (3) tick();
    check("t3_exactly_one_more", ack_cnt, 32'd9);

    // Holder stalls mid-packet: forced release after TIMEOUT idle cycles
    reset_all();
    push_pkt(0, 3, 8'hA0, 1);
    drive();
    tick();
    tick();
    check("t4_first_ack", {28'b0, samp_ack}, 32'd1);
    mute[0] = 1'b1;
    push_pkt(1, 1, 8'h55, 1);
    drive();
    repeat (TIMEOUT - 1) tick();
    check("t4_grant_before_timeout", {28'b0, grant}, 32'd1);
    check("t4_no_timeout_yet", {31'b0, timeout}, 32'd0);
    tick();
    check("t4_released", {28'b0, grant}, 32'd0);
    check("t4_timeout_flag", {31'b0, timeout}, 32'd1);
    tick();
    check("t4_req1_granted", {28'b0, grant}, 32'd2);
    tick();
    check("t4_req1_ack", {28'b0, samp_ack}, 32'd2);
    check("t4_timeout_sticky", {31'b0, timeout}, 32'd1);
    check("t4_drained", exp_q.size(), 32'd0);

    // Underflow at zero credits, then simultaneous write and done at 5 credits
    reset_all();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    check("t5_credits_floor", {28'b0, credits}, 32'd0);
    check("t5_underflow", {31'b0, underflow}, 32'd1);
    push_pkt(3, 7, 8'hC0, 7);
    drive();
    tick();
    repeat (5) tick();
    check("t5_credits_5", {28'b0, credits}, 32'd5);
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    check("t5_ack_with_done", {28'b0, samp_ack}, 32'd8);
    check("t5_credits_unchanged", {28'b0, credits}, 32'd5);
    tick();
    check("t5_credits_6", {28'b0, credits}, 32'd6);
    check("t5_underflow_sticky", {31'b0, underflow}, 32'd1);
    wait_drain(5);

    // Reset mid-packet with 4 bytes in flight
    reset_all();
    push_pkt(2, 6, 8'hE0, 5);
    drive();
    tick();
    repeat (4) tick();
    check("t6_credits_4", {28'b0, credits}, 32'd4);
    check("t6_granted", {28'b0, grant}, 32'd4);
    i_rst = 1'b1;
    tick();
    check("t6_grant_cleared", {28'b0, grant}, 32'd0);
    check("t6_credits_cleared", {28'b0, credits}, 32'd0);
    check("t6_timeout_cleared", {31'b0, timeout}, 32'd0);
    check("t6_underflow_cleared", {31'b0, underflow}, 32'd0);
    tick();
    check("t6_no_ack_after_reset", {28'b0, samp_ack}, 32'd0);
    check("t6_no_write_after_reset", {31'b0, samp_write}, 32'd0);
    reset_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
